// File: rtl/mgmt_sram_arbiter.sv
// Two-port Wishbone classic round-robin arbiter in front of the management SRAM macro.
// Optional contention counter output enabled by defining SRAM_ARB_CONFLICT_CNT_EN.
module mgmt_sram_arbiter #(
    parameter int ADR_WIDTH = 8,
    parameter int DAT_WIDTH = 32
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs0_cyc_i,
    input  logic                   wbs0_stb_i,
    input  logic                   wbs0_we_i,
    input  logic [DAT_WIDTH/8-1:0] wbs0_sel_i,
    input  logic [31:0]            wbs0_adr_i,
    input  logic [DAT_WIDTH-1:0]   wbs0_dat_i,
    output logic [DAT_WIDTH-1:0]   wbs0_dat_o,
    output logic                   wbs0_ack_o,
    input  logic                   wbs1_cyc_i,
    input  logic                   wbs1_stb_i,
    input  logic                   wbs1_we_i,
    input  logic [DAT_WIDTH/8-1:0] wbs1_sel_i,
    input  logic [31:0]            wbs1_adr_i,
    input  logic [DAT_WIDTH-1:0]   wbs1_dat_i,
    output logic [DAT_WIDTH-1:0]   wbs1_dat_o,
    output logic                   wbs1_ack_o,
    output logic                   sram_csb0_o,
    output logic                   sram_web0_o,
    output logic [DAT_WIDTH/8-1:0] sram_wmask0_o,
    output logic [ADR_WIDTH-1:0]   sram_addr0_o,
    output logic [DAT_WIDTH-1:0]   sram_din0_o,
    input  logic [DAT_WIDTH-1:0]   sram_dout0_i
`ifdef SRAM_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]            conflict_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_r;
    logic                   last_grant_r;
    logic                   grant_r;
    logic                   we_r;
    logic                   req0_s;
    logic                   req1_s;
    logic                   grant_s;
    logic                   gnt_we_s;
    logic [DAT_WIDTH/8-1:0] gnt_sel_s;
    logic [ADR_WIDTH-1:0]   gnt_word_s;
    logic [DAT_WIDTH-1:0]   gnt_dat_s;
    logic                   unused_adr_s;

    assign req0_s = wbs0_cyc_i & wbs0_stb_i;
    assign req1_s = wbs1_cyc_i & wbs1_stb_i;

    // Byte-offset and upstream-decoded address bits play no part in the SRAM word address.
    assign unused_adr_s = ^{wbs0_adr_i[31:ADR_WIDTH+2], wbs0_adr_i[1:0],
                            wbs1_adr_i[31:ADR_WIDTH+2], wbs1_adr_i[1:0]};

    // Round-robin pick: on contention the port that did not win last time goes first.
    always_comb begin
        grant_s = 1'b0;
        if (req0_s && req1_s) begin
            grant_s = ~last_grant_r;
        end else if (req1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Steer the winning port's request fields toward the SRAM output registers.
    always_comb begin
        gnt_we_s   = 1'b0;
        gnt_sel_s  = {(DAT_WIDTH/8){1'b0}};
        gnt_word_s = {ADR_WIDTH{1'b0}};
        gnt_dat_s  = {DAT_WIDTH{1'b0}};
        if (grant_s) begin
            gnt_we_s   = wbs1_we_i;
            gnt_sel_s  = wbs1_sel_i;
            gnt_word_s = wbs1_adr_i[ADR_WIDTH+1:2];
            gnt_dat_s  = wbs1_dat_i;
        end else begin
            gnt_we_s   = wbs0_we_i;
            gnt_sel_s  = wbs0_sel_i;
            gnt_word_s = wbs0_adr_i[ADR_WIDTH+1:2];
            gnt_dat_s  = wbs0_dat_i;
        end
    end

    // Access sequencer: IDLE issues the SRAM access, MEM lets the macro sample it, RESP acks.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r       <= IDLE;
            last_grant_r  <= 1'b1;
            grant_r       <= 1'b0;
            we_r          <= 1'b0;
            wbs0_ack_o    <= 1'b0;
            wbs1_ack_o    <= 1'b0;
            sram_csb0_o   <= 1'b1;
            sram_web0_o   <= 1'b1;
            sram_wmask0_o <= {(DAT_WIDTH/8){1'b0}};
            sram_addr0_o  <= {ADR_WIDTH{1'b0}};
            sram_din0_o   <= {DAT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    wbs0_ack_o <= 1'b0;
                    wbs1_ack_o <= 1'b0;
                    if (req0_s || req1_s) begin
                        state_r       <= MEM;
                        grant_r       <= grant_s;
                        last_grant_r  <= grant_s;
                        we_r          <= gnt_we_s;
                        sram_csb0_o   <= 1'b0;
                        sram_web0_o   <= ~gnt_we_s;
                        sram_wmask0_o <= gnt_we_s ? gnt_sel_s : {(DAT_WIDTH/8){1'b0}};
                        sram_addr0_o  <= gnt_word_s;
                        sram_din0_o   <= gnt_dat_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEM: begin
                    // A master that dropped cyc gets no ack; the issued write still lands.
                    state_r     <= RESP;
                    sram_csb0_o <= 1'b1;
                    sram_web0_o <= 1'b1;
                    wbs0_ack_o  <= (grant_r == 1'b0) && wbs0_cyc_i;
                    wbs1_ack_o  <= (grant_r == 1'b1) && wbs1_cyc_i;
                end
                RESP: begin
                    state_r    <= IDLE;
                    wbs0_ack_o <= 1'b0;
                    wbs1_ack_o <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    sram_csb0_o <= 1'b1;
                    sram_web0_o <= 1'b1;
                    wbs0_ack_o  <= 1'b0;
                    wbs1_ack_o  <= 1'b0;
                end
            endcase
        end
    end

    // Read data arrives from the macro in the RESP cycle, so it is routed straight through.
    always_comb begin
        wbs0_dat_o = {DAT_WIDTH{1'b0}};
        wbs1_dat_o = {DAT_WIDTH{1'b0}};
        if (wbs0_ack_o && !we_r) begin
            wbs0_dat_o = sram_dout0_i;
        end else begin
            wbs0_dat_o = {DAT_WIDTH{1'b0}};
        end
        if (wbs1_ack_o && !we_r) begin
            wbs1_dat_o = sram_dout0_i;
        end else begin
            wbs1_dat_o = {DAT_WIDTH{1'b0}};
        end
    end

`ifdef SRAM_ARB_CONFLICT_CNT_EN
    // Saturating count of IDLE cycles in which both ports were requesting.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            conflict_cnt_o <= 16'h0000;
        end else if ((state_r == IDLE) && req0_s && req1_s && (conflict_cnt_o != 16'hFFFF)) begin
            conflict_cnt_o <= conflict_cnt_o + 16'd1;
        end else begin
            conflict_cnt_o <= conflict_cnt_o;
        end
    end
`endif

endmodule

// File: tb/tb_mgmt_sram_arbiter.sv
// Scoreboard bench for mgmt_sram_arbiter: behavioural SRAM, per-port read-data queues
// and an SRAM-operation queue, all filled from a reference memory when stimulus is driven.
module tb_mgmt_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0, s0, w0, ack0;
    logic [3:0]  sel0;
    logic [31:0] adr0, di0, do0;
    logic        c1, s1, w1, ack1;
    logic [3:0]  sel1;
    logic [31:0] adr1, di1, do1;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [31:0] din, dout;
`ifdef SRAM_ARB_CONFLICT_CNT_EN
    logic [15:0] ccnt;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic        web;
        logic [3:0]  wmask;
        logic [7:0]  addr;
        logic [31:0] din;
    } op_t;

    logic [31:0] sram [256];
    logic [31:0] ref_mem [256];
    op_t         op_q [$];
    logic [31:0] exp0_q [$];
    logic [31:0] exp1_q [$];

    always #5 clk = ~clk;

    mgmt_sram_arbiter #(.ADR_WIDTH(8), .DAT_WIDTH(32)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs0_cyc_i(c0), .wbs0_stb_i(s0), .wbs0_we_i(w0), .wbs0_sel_i(sel0),
        .wbs0_adr_i(adr0), .wbs0_dat_i(di0), .wbs0_dat_o(do0), .wbs0_ack_o(ack0),
        .wbs1_cyc_i(c1), .wbs1_stb_i(s1), .wbs1_we_i(w1), .wbs1_sel_i(sel1),
        .wbs1_adr_i(adr1), .wbs1_dat_i(di1), .wbs1_dat_o(do1), .wbs1_ack_o(ack1),
        .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask),
        .sram_addr0_o(addr), .sram_din0_o(din), .sram_dout0_i(dout)
`ifdef SRAM_ARB_CONFLICT_CNT_EN
        , .conflict_cnt_o(ccnt)
`endif
    );

    // Behavioural single-port SRAM: read data appears the cycle after csb is sampled low.
    always @(posedge clk) begin
        if (csb === 1'b0) begin
            if (web === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) sram[addr][b*8 +: 8] <= din[b*8 +: 8];
            end else begin
                dout <= sram[addr];
            end
        end
    end

    // Output monitor: compares SRAM pin activity and acknowledged data against the queues.
    always @(negedge clk) begin : mon
        op_t         e;
        logic [31:0] d;
        if (mon_en) begin
            if (csb === 1'b0) begin
                checks++;
                if (op_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_op: unexpected access web=%b wmask=%h addr=%h din=%h", web, wmask, addr, din);
                end else begin
                    e = op_q.pop_front();
                    if ({web, wmask, addr, din} !== e) begin
                        errors++;
                        $display("FAIL sram_op: got web=%b wmask=%h addr=%h din=%h, want web=%b wmask=%h addr=%h din=%h",
                                 web, wmask, addr, din, e.web, e.wmask, e.addr, e.din);
                    end
                end
            end
            checks++;
            if (ack0 === 1'b1) begin
                if (exp0_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack0: unexpected ack, dat_o=%h", do0);
                end else begin
                    d = exp0_q.pop_front();
                    if (do0 !== d) begin
                        errors++;
                        $display("FAIL dat0: got %h want %h", do0, d);
                    end
                end
            end else if (do0 !== 32'h0) begin
                errors++;
                $display("FAIL dat0_idle: got %h want 00000000 (ack0=%b)", do0, ack0);
            end
            checks++;
            if (ack1 === 1'b1) begin
                if (exp1_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack1: unexpected ack, dat_o=%h", do1);
                end else begin
                    d = exp1_q.pop_front();
                    if (do1 !== d) begin
                        errors++;
                        $display("FAIL dat1: got %h want %h", do1, d);
                    end
                end
            end else if (do1 !== 32'h0) begin
                errors++;
                $display("FAIL dat1_idle: got %h want 00000000 (ack1=%b)", do1, ack1);
            end
        end
    end

    task automatic push_op(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        op_t o;
        o.web   = ~we;
        o.wmask = we ? sel : 4'h0;
        o.addr  = adr[9:2];
        o.din   = dat;
        op_q.push_back(o);
    endtask

    // One Wishbone classic access; returns cycles from request to ack (-1 on timeout).
    task automatic master(input int p, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int lat);
        logic [31:0] e;
        logic [7:0]  w;
        w = adr[9:2];
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[w][b*8 +: 8] = dat[b*8 +: 8];
            e = 32'h0;
        end else begin
            e = ref_mem[w];
        end
        if (p == 0) begin
            exp0_q.push_back(e);
            c0 = 1'b1; s0 = 1'b1; w0 = we; sel0 = sel; adr0 = adr; di0 = dat;
        end else begin
            exp1_q.push_back(e);
            c1 = 1'b1; s1 = 1'b1; w1 = we; sel1 = sel; adr1 = adr; di1 = dat;
        end
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (((p == 0) ? ack0 : ack1) === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: port%0d no ack within 20 cycles", p);
        end
        @(posedge clk);
        #1;
        if (p == 0) begin c0 = 1'b0; s0 = 1'b0; end
        else begin c1 = 1'b0; s1 = 1'b0; end
    endtask

    task automatic access(input int p, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int want_lat, input string name);
        int lat;
        push_op(we, adr, dat, sel);
        master(p, we, adr, dat, sel, lat);
        checks++;
        if (lat != want_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, want_lat);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({csb, web} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ctrl: got csb=%b web=%b want 1 1", csb, web);
        end
        checks++;
        if ({wmask, addr, din} !== 44'h0) begin
            errors++;
            $display("FAIL reset_data: got wmask=%h addr=%h din=%h want 0", wmask, addr, din);
        end
        checks++;
        if ({ack0, ack1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ack: got %b%b want 00", ack0, ack1);
        end
`ifdef SRAM_ARB_CONFLICT_CNT_EN
        checks++;
        if (ccnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ccnt: got %h want 0000", ccnt);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, "wr0");
        access(0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 2, "rd0");
    endtask

    task automatic test_byte_write();
        access(1, 1'b1, 32'h0000_0010, 32'h0000_AB00, 4'b0010, 2, "bytewr1");
        access(1, 1'b0, 32'h0000_0010, 32'h0,         4'hF,    2, "byterd1");
    endtask

    task automatic test_contention();
        int l0, l1;
        apply_reset();
        push_op(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        push_op(1'b1, 32'h0000_0020, 32'h0000_55AA, 4'hF);
        fork
            master(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, l0);
            master(1, 1'b1, 32'h0000_0020, 32'h0000_55AA, 4'hF, l1);
        join
        checks++;
        if (l0 != 2 || l1 != 5) begin
            errors++;
            $display("FAIL contend1_order: got lat0=%0d lat1=%0d want 2 5", l0, l1);
        end
`ifdef SRAM_ARB_CONFLICT_CNT_EN
        checks++;
        if (ccnt !== 16'd1) begin
            errors++;
            $display("FAIL ccnt1: got %0d want 1", ccnt);
        end
`endif
        push_op(1'b1, 32'h0000_0024, 32'h0000_0001, 4'hF);
        push_op(1'b0, 32'h0000_0020, 32'h0, 4'hF);
        fork
            master(0, 1'b1, 32'h0000_0024, 32'h0000_0001, 4'hF, l0);
            master(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, l1);
        join
        checks++;
        if (l0 != 2 || l1 != 5) begin
            errors++;
            $display("FAIL contend2_order: got lat0=%0d lat1=%0d want 2 5", l0, l1);
        end
`ifdef SRAM_ARB_CONFLICT_CNT_EN
        checks++;
        if (ccnt !== 16'd2) begin
            errors++;
            $display("FAIL ccnt2: got %0d want 2", ccnt);
        end
`endif
    endtask

    task automatic test_abort();
        push_op(1'b1, 32'h0000_0030, 32'h1234_5678, 4'hF);
        ref_mem[8'h0C] = 32'h1234_5678;
        c0 = 1'b1; s0 = 1'b1; w0 = 1'b1; sel0 = 4'hF; adr0 = 32'h0000_0030; di0 = 32'h1234_5678;
        @(posedge clk);
        #1 c0 = 1'b0; s0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== 1'b0) begin
                errors++;
                $display("FAIL abort_ack: cycle %0d got ack0=%b want 0", k, ack0);
            end
        end
        @(posedge clk);
        #1;
        access(0, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 2, "abort_rd");
    endtask

    task automatic test_reset_mid();
        push_op(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        c0 = 1'b1; s0 = 1'b1; w0 = 1'b0; sel0 = 4'hF; adr0 = 32'h0000_0010; di0 = 32'h0;
        @(posedge clk);
        #1 rst = 1'b1; c0 = 1'b0; s0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({csb, ack0} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid: got csb=%b ack0=%b want 1 0", csb, ack0);
        end
        @(posedge clk);
        #1;
        access(0, 1'b1, 32'h0000_0014, 32'hA5A5_5A5A, 4'hF, 2, "postrst_wr");
        access(0, 1'b0, 32'h0000_0014, 32'h0,         4'hF, 2, "postrst_rd");
    endtask

    task automatic test_wrap();
        access(0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 2, "wrap_wr");
        access(1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 2, "wrap_rd");
    endtask

    initial begin
        rst = 1'b1;
        c0 = 1'b0; s0 = 1'b0; w0 = 1'b0; sel0 = 4'h0; adr0 = 32'h0; di0 = 32'h0;
        c1 = 1'b0; s1 = 1'b0; w1 = 1'b0; sel1 = 4'h0; adr1 = 32'h0; di1 = 32'h0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_contention();
        test_abort();
        test_reset_mid();
        test_wrap();
        repeat (3) @(posedge clk);
        checks++;
        if (op_q.size() != 0 || exp0_q.size() != 0 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got op=%0d exp0=%0d exp1=%0d pending want 0 0 0",
                     op_q.size(), exp0_q.size(), exp1_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
